// File: rtl/rtc_sample_scheduler_if.sv
// Signal bundle between the RTC sample scheduler, rtc_control and the
// sensor front-end. The scheduler side uses the master modport; the
// environment (rtc_control model, sensor, host) uses the slave modport.
interface rtc_sample_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] period;
  logic                  ctrl_read_time_en;
  logic [DATA_WIDTH-1:0] ctrl_time_value;
  logic                  ctrl_set_match_en;
  logic [DATA_WIDTH-1:0] ctrl_match_value;
  logic                  ctrl_intr_flag;
  logic                  ctrl_clear_intr;
  logic                  sample_req;
  logic                  sample_ack;
  logic [DATA_WIDTH-1:0] sample_timestamp;
  logic [15:0]           sample_count;
  logic                  busy;
  logic                  ack_err;

  modport master (
    input  enable, period, ctrl_time_value, ctrl_intr_flag, sample_ack,
    output ctrl_read_time_en, ctrl_set_match_en, ctrl_match_value,
           ctrl_clear_intr, sample_req, sample_timestamp, sample_count,
           busy, ack_err
  );

  modport slave (
    output enable, period, ctrl_time_value, ctrl_intr_flag, sample_ack,
    input  ctrl_read_time_en, ctrl_set_match_en, ctrl_match_value,
           ctrl_clear_intr, sample_req, sample_timestamp, sample_count,
           busy, ack_err
  );
endinterface

// File: rtl/rtc_sample_scheduler.sv
// RTC sample scheduler: reads the RTC time once, then programs drift-free
// periodic match times into rtc_control and runs a req/ack handshake with
// the sensor front-end at every match interrupt.
// Optional feature macro: RTC_SCHED_ACK_TIMEOUT_EN enables an ACK_TIMEOUT
// cycle limit on the sensor handshake with a sticky ack_err flag.
module rtc_sample_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  rtc_sample_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_CAPTURE   = 3'd2,
    S_ARM       = 3'd3,
    S_WAIT_INTR = 3'd4,
    S_CLEAR     = 3'd5,
    S_REQ       = 3'd6
  } state_t;

  state_t                r_state;
  logic                  r_read_en;
  logic                  r_set_match;
  logic                  r_clear_intr;
  logic                  r_sample_req;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_match_value;
  logic [DATA_WIDTH-1:0] r_next_match;
  logic [DATA_WIDTH-1:0] r_timestamp;
  logic [DATA_WIDTH-1:0] r_period;
  logic [15:0]           r_count;

  logic [DATA_WIDTH-1:0] w_period_eff;
  logic [DATA_WIDTH-1:0] w_next_plus;
  logic                  w_timeout;

  // A zero period would re-arm on the same tick forever, so it counts as 1.
  assign w_period_eff = (bus.period == {DATA_WIDTH{1'b0}}) ? DATA_WIDTH'(1) : bus.period;
  // Next match advances from the previous match, never from a fresh read.
  assign w_next_plus  = r_next_match + w_period_eff;

`ifdef RTC_SCHED_ACK_TIMEOUT_EN
  localparam int                CW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]     TO_LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_ack_err;

  // Timeout fires on the ACK_TIMEOUT-th REQ cycle without an ack.
  assign w_timeout = (r_state == S_REQ) && !bus.sample_ack && (r_to_cnt == TO_LAST);

  // Count un-acked REQ cycles and keep the sticky timeout flag.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_to_cnt  <= '0;
      r_ack_err <= 1'b0;
    end else begin
      if ((r_state == S_REQ) && !bus.sample_ack && !w_timeout) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_ack_err <= 1'b1;
      end else if ((r_state == S_IDLE) && !bus.enable) begin
        r_ack_err <= 1'b0;
      end else begin
        r_ack_err <= r_ack_err;
      end
    end
  end

  assign bus.ack_err = r_ack_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.ack_err = 1'b0;
`endif

  // Scheduler FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= S_IDLE;
      r_read_en     <= 1'b0;
      r_set_match   <= 1'b0;
      r_clear_intr  <= 1'b0;
      r_sample_req  <= 1'b0;
      r_busy        <= 1'b0;
      r_match_value <= '0;
      r_next_match  <= '0;
      r_timestamp   <= '0;
      r_period      <= '0;
      r_count       <= 16'd0;
    end else begin
      r_read_en    <= 1'b0;
      r_set_match  <= 1'b0;
      r_clear_intr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_state   <= S_READ;
            r_read_en <= 1'b1;
            r_period  <= w_period_eff;
            r_busy    <= 1'b1;
          end else begin
            r_busy    <= 1'b0;
          end
        end
        S_READ: begin
          // rtc_control presents the time during the following cycle.
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_state       <= S_ARM;
          r_next_match  <= bus.ctrl_time_value + r_period;
          r_match_value <= bus.ctrl_time_value + r_period;
          r_set_match   <= 1'b1;
        end
        S_ARM: begin
          r_state <= S_WAIT_INTR;
        end
        S_WAIT_INTR: begin
          // Disable has priority over a coincident interrupt.
          if (!bus.enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.ctrl_intr_flag) begin
            r_state      <= S_CLEAR;
            r_clear_intr <= 1'b1;
          end else begin
            r_state <= S_WAIT_INTR;
          end
        end
        S_CLEAR: begin
          r_state      <= S_REQ;
          r_timestamp  <= r_next_match;
          r_sample_req <= 1'b1;
        end
        S_REQ: begin
          if (bus.sample_ack || w_timeout) begin
            r_sample_req <= 1'b0;
            r_next_match <= w_next_plus;
            if (bus.sample_ack) begin
              r_count <= r_count + 16'd1;
            end else begin
              r_count <= r_count;
            end
            if (bus.enable) begin
              r_state       <= S_ARM;
              r_match_value <= w_next_plus;
              r_set_match   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_sample_req <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_read_time_en = r_read_en;
  assign bus.ctrl_set_match_en = r_set_match;
  assign bus.ctrl_match_value  = r_match_value;
  assign bus.ctrl_clear_intr   = r_clear_intr;
  assign bus.sample_req        = r_sample_req;
  assign bus.sample_timestamp  = r_timestamp;
  assign bus.sample_count      = r_count;
  assign bus.busy              = r_busy;

endmodule

// File: tb/tb_rtc_sample_scheduler.sv
// Directed testbench for rtc_sample_scheduler with hand-computed expectations.
// The timeout section follows RTC_SCHED_ACK_TIMEOUT_EN when it is defined.
module tb_rtc_sample_scheduler;

  localparam int DW = 32;

  logic PCLK;
  logic PRESET;
  int   n_total;
  int   n_bad;

  rtc_sample_scheduler_if #(.DATA_WIDTH(DW)) bus_if ();

  rtc_sample_scheduler #(
    .DATA_WIDTH (DW),
    .ACK_TIMEOUT(8)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus_if)
  );

  // Free-running 100 MHz clock.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    n_total = 0;
    n_bad   = 0;
    PRESET  = 1'b1;
    bus_if.enable          = 1'b0;
    bus_if.period          = 32'd10;
    bus_if.ctrl_time_value = 32'd100;
    bus_if.ctrl_intr_flag  = 1'b0;
    bus_if.sample_ack      = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus_if.busy, 64'd0);
    chk("rst_req", bus_if.sample_req, 64'd0);
    chk("rst_count", bus_if.sample_count, 64'd0);
    chk("rst_match", bus_if.ctrl_match_value, 64'd0);
    chk("rst_read", bus_if.ctrl_read_time_en, 64'd0);
    chk("rst_ackerr", bus_if.ack_err, 64'd0);

    // Basic flow: base 100, period 10.
    PRESET = 1'b0;
    bus_if.enable = 1'b1;
    tick();
    chk("read_pulse", bus_if.ctrl_read_time_en, 64'd1);
    chk("busy_on", bus_if.busy, 64'd1);
    tick();
    chk("read_one_cyc", bus_if.ctrl_read_time_en, 64'd0);
    tick();
    chk("set_match", bus_if.ctrl_set_match_en, 64'd1);
    chk("match_110", bus_if.ctrl_match_value, 64'd110);
    tick();
    chk("set_one_cyc", bus_if.ctrl_set_match_en, 64'd0);
    chk("match_hold", bus_if.ctrl_match_value, 64'd110);
    bus_if.ctrl_intr_flag = 1'b1;
    tick();
    chk("clear_pulse", bus_if.ctrl_clear_intr, 64'd1);
    chk("req_not_yet", bus_if.sample_req, 64'd0);
    bus_if.ctrl_intr_flag = 1'b0;
    tick();
    chk("req_on", bus_if.sample_req, 64'd1);
    chk("ts_110", bus_if.sample_timestamp, 64'd110);
    chk("clear_one_cyc", bus_if.ctrl_clear_intr, 64'd0);
    tick();
    chk("req_hold", bus_if.sample_req, 64'd1);
    bus_if.sample_ack = 1'b1;
    tick();
    chk("req_drop", bus_if.sample_req, 64'd0);
    chk("count_1", bus_if.sample_count, 64'd1);
    chk("match_120", bus_if.ctrl_match_value, 64'd120);
    chk("rearm_pulse", bus_if.ctrl_set_match_en, 64'd1);
    bus_if.sample_ack = 1'b0;
    tick();

    // Disable and interrupt together in WAIT_INTR: disable wins.
    bus_if.enable = 1'b0;
    bus_if.ctrl_intr_flag = 1'b1;
    tick();
    chk("dis_busy", bus_if.busy, 64'd0);
    chk("dis_noclear", bus_if.ctrl_clear_intr, 64'd0);
    bus_if.ctrl_intr_flag = 1'b0;

    // Wrap-around base.
    bus_if.ctrl_time_value = 32'hFFFF_FFFA;
    bus_if.enable = 1'b1;
    tick();
    tick();
    tick();
    chk("wrap_match", bus_if.ctrl_match_value, 64'h0000_0004);
    tick();
    bus_if.ctrl_intr_flag = 1'b1;
    tick();
    bus_if.ctrl_intr_flag = 1'b0;
    tick();
    chk("wrap_ts", bus_if.sample_timestamp, 64'h0000_0004);
    // Disable during REQ: handshake still completes.
    bus_if.enable = 1'b0;
    tick();
    chk("dis_req_hold", bus_if.sample_req, 64'd1);
    bus_if.sample_ack = 1'b1;
    tick();
    chk("dis_req_done", bus_if.sample_req, 64'd0);
    chk("dis_req_idle", bus_if.busy, 64'd0);
    chk("count_2", bus_if.sample_count, 64'd2);
    chk("dis_no_rearm", bus_if.ctrl_set_match_en, 64'd0);
    // Ack outside REQ is ignored.
    tick();
    chk("stray_ack", bus_if.sample_count, 64'd2);
    bus_if.sample_ack = 1'b0;

    // Period 0 behaves as 1.
    bus_if.period = 32'd0;
    bus_if.enable = 1'b1;
    tick();
    tick();
    tick();
    chk("p0_match", bus_if.ctrl_match_value, 64'hFFFF_FFFB);
    tick();
    bus_if.ctrl_intr_flag = 1'b1;
    tick();
    bus_if.ctrl_intr_flag = 1'b0;
    tick();
    chk("p0_req", bus_if.sample_req, 64'd1);

`ifdef RTC_SCHED_ACK_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("to_req_7", bus_if.sample_req, 64'd1);
    chk("to_err_0", bus_if.ack_err, 64'd0);
    tick();
    chk("to_req_drop", bus_if.sample_req, 64'd0);
    chk("to_err_1", bus_if.ack_err, 64'd1);
    chk("to_count", bus_if.sample_count, 64'd2);
    chk("to_rearm", bus_if.ctrl_set_match_en, 64'd1);
    chk("to_match", bus_if.ctrl_match_value, 64'hFFFF_FFFC);
    tick();
    bus_if.ctrl_intr_flag = 1'b1;
    tick();
    bus_if.ctrl_intr_flag = 1'b0;
    tick();
    chk("to_req_again", bus_if.sample_req, 64'd1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("noto_req", bus_if.sample_req, 64'd1);
    chk("noto_err", bus_if.ack_err, 64'd0);
`endif

    // Reset in the middle of a handshake.
    bus_if.sample_ack = 1'b0;
    PRESET = 1'b1;
    tick();
    chk("mrst_req", bus_if.sample_req, 64'd0);
    chk("mrst_busy", bus_if.busy, 64'd0);
    chk("mrst_count", bus_if.sample_count, 64'd0);
    chk("mrst_ts", bus_if.sample_timestamp, 64'd0);
    chk("mrst_match", bus_if.ctrl_match_value, 64'd0);
    chk("mrst_err", bus_if.ack_err, 64'd0);
    // First cycle after release samples enable.
    PRESET = 1'b0;
    tick();
    chk("post_rst_read", bus_if.ctrl_read_time_en, 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
